// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and frame/id sizing helpers for the UART TX scheduler
package uart_pkg;
  typedef enum logic [1:0] {IDLE, PULSE, WAIT} state_t;
  function automatic int frame_cycles(input int clk_hz, input int baud, input int guard);
    return 10 * (clk_hz / baud + 1) + guard;
  endfunction
  function automatic int id_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/uart_tx_scheduler_if.sv
// uart_tx_scheduler_if: requester handshake bundle plus the TX-side outputs of the scheduler
interface uart_tx_scheduler_if
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = id_width(N_REQ)
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic [7:0]         send_byte;
  logic               send_en;
  logic               busy;
  logic [IDW-1:0]     grant_id;
  logic               locked;
  modport master(
    output req_valid, req_data, req_last,
    input  req_ready, send_byte, send_en, busy, grant_id, locked
  );
  modport slave(
    input  req_valid, req_data, req_last,
    output req_ready, send_byte, send_en, busy, grant_id, locked
  );
endinterface

// File: rtl/uart_rr_picker.sv
// uart_rr_picker: round-robin winner search from a pointer, restricted to the lock owner when locked
module uart_rr_picker
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDW-1:0]   i_ptr,
  input  logic             i_lock_en,
  input  logic [IDW-1:0]   i_lock_id,
  output logic             o_valid,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDW-1:0]   o_id
);
  logic [N_REQ-1:0] w_mask;
  assign w_mask = i_lock_en ? i_req & (N_REQ'(1) << i_lock_id) : i_req;
  // walk from the farthest offset back to ptr so the nearest set bit is the last one written
  always_comb begin
    o_valid = 1'b0;
    o_id    = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (w_mask[(int'(i_ptr) + k) % N_REQ]) begin
        o_valid = 1'b1;
        o_id    = IDW'((int'(i_ptr) + k) % N_REQ);
      end
  end
  assign o_grant = o_valid ? N_REQ'(1) << o_id : '0;
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one UART TX between N requesters, one send_en pulse per byte, frame-timed
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int INPUT_CLK    = 50000000,
  parameter int BAUD_RATE    = 230400,
  parameter int GUARD_CYCLES = 4
) (
  input logic                clk,
  input logic                kill,
  uart_tx_scheduler_if.slave bus
);
  localparam int IDW          = id_width(N_REQ);
  localparam int FRAME_CYCLES = frame_cycles(INPUT_CLK, BAUD_RATE, GUARD_CYCLES);
  localparam int TW           = $clog2(FRAME_CYCLES + 1);
  state_t           r_state, w_next;
  logic [IDW-1:0]   r_ptr, r_grant_id, w_id, w_ptr_next;
  logic             r_locked, w_valid, w_accept, w_last;
  logic [N_REQ-1:0] w_onehot;
  logic [7:0]       r_byte, w_data;
  logic [TW-1:0]    r_timer;
  uart_rr_picker #(.N_REQ(N_REQ), .IDW(IDW)) u_picker (
    .i_req     (bus.req_valid),
    .i_ptr     (r_ptr),
    .i_lock_en (r_locked),
    .i_lock_id (r_grant_id),
    .o_valid   (w_valid),
    .o_grant   (w_onehot),
    .o_id      (w_id)
  );
  assign w_accept   = !kill && r_state == IDLE && w_valid;
  assign w_data     = bus.req_data[8*w_id +: 8];
  assign w_last     = bus.req_last[w_id];
  assign w_ptr_next = w_id == IDW'(N_REQ - 1) ? '0 : w_id + 1'b1;
  // IDLE waits for a winner, PULSE lasts one cycle, WAIT runs until the frame timer reaches 1
  always_comb begin
    w_next = r_state == IDLE  ? (w_accept ? PULSE : IDLE) :
             r_state == PULSE ? WAIT :
             r_timer == TW'(1) ? IDLE : WAIT;
  end
  // state, captured byte, grant/lock bookkeeping and frame timer
  always_ff @(posedge clk) begin
    if (kill) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_grant_id <= '0;
      r_locked   <= 1'b0;
      r_byte     <= '0;
      r_timer    <= '0;
    end else begin
      r_state <= w_next;
      r_timer <= r_state == PULSE ? TW'(FRAME_CYCLES) : r_state == WAIT ? r_timer - 1'b1 : r_timer;
      if (w_accept) begin
        r_byte     <= w_data;
        r_grant_id <= w_id;
        r_locked   <= !w_last;
        if (w_last) r_ptr <= w_ptr_next;
      end
    end
  end
  assign bus.req_ready = w_accept ? w_onehot : '0;
  assign bus.send_en   = !kill && r_state == PULSE;
  assign bus.busy      = !kill && r_state != IDLE;
  assign bus.send_byte = r_byte;
  assign bus.grant_id  = r_grant_id;
  assign bus.locked    = r_locked;
endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares one UART_module_TX instance between N byte-stream requesters. Per-requester valid/ready interface with a packet "last" flag; round-robin between packets, grant locked for the length of a packet.
The TX datapath has no busy output, so this block times each frame itself and emits exactly one single-cycle send_en pulse per byte. It sits between the application producers and the TX serializer and shares its clk/kill.

Parameters:
N_REQ, 4, number of requesters (1..16)
INPUT_CLK, 50000000, clock frequency in Hz (must match TX instance)
BAUD_RATE, 230400, baud rate (must match TX instance)
GUARD_CYCLES, 4, extra idle cycles appended after each frame
Derived localparams: BIT_CYCLES = INPUT_CLK/BAUD_RATE + 1; FRAME_CYCLES = 10*BIT_CYCLES + GUARD_CYCLES (2184 at defaults); IDW = max(1, clog2(N_REQ)).

Ports:
clk  in  1  system clock
kill  in  1  synchronous active-high reset
req_valid  in  N_REQ  per-requester byte valid
req_data  in  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_last  in  N_REQ  byte is last of its packet
req_ready  out  N_REQ  one-hot accept; transfer when valid&ready on the same edge
send_byte  out  8  to TX send_byte
send_en  out  1  to TX send_en; one-cycle pulse per byte
busy  out  1  high from accept until frame timer expires
grant_id  out  IDW  index of the last accepted requester
locked  out  1  a packet is in progress (grant held)

Behaviour:
- Clock and reset: clk is the single clock. kill is synchronous active-high. While kill is high: state=IDLE, send_en=0, send_byte=0, busy=0, req_ready=0, grant_id=0, locked=0, RR pointer=0, frame timer=0.
- kill mid-frame: abort immediately with no further pulse. The TX instance shares kill, so the line returns to idle-high.
- States: IDLE, PULSE, WAIT.
- IDLE transition: when any eligible req_valid is set, req_ready[w] is asserted combinationally for winner w in that same cycle. Transfer happens on that edge. Next state is PULSE.
- In PULSE (1 cycle):
  - send_byte holds the registered req_data[w] and send_en=1.
  - The timer is loaded with FRAME_CYCLES.
  - Next state is WAIT.
- In WAIT: send_en=0 and the timer decrements each cycle. At 1, the next state is IDLE. WAIT lasts exactly FRAME_CYCLES cycles.
- Timing:
  - Back-to-back send_en pulses are spaced exactly FRAME_CYCLES+2 cycles apart.
  - Latency from accept edge to send_en high is 1 cycle.
  - send_byte holds its value until the next accept.
- req_ready is 0 outside IDLE and is never asserted to a requester with req_valid=0.
- busy is 1 in PULSE and WAIT, 0 in IDLE.
- Eligibility:
  - If locked=1, only the lock owner (grant_id) is eligible. Others stall even if valid.
  - If the owner drops valid, the scheduler waits indefinitely. There is no timeout.
- Arbitration when unlocked:
  - Search req_valid from index ptr upward, wrapping modulo N_REQ. The first set bit wins.
  - ptr resets to 0, so requester 0 has highest priority after reset.
- On accept of requester w:
  - grant_id <= w.
  - If req_last[w]=0: locked <= 1.
  - If req_last[w]=1: locked <= 0 and ptr <= (w+1) mod N_REQ. ptr only moves at packet end.
  - Single-byte packets (last=1 while unlocked) do not set the lock.
- N_REQ=1: arbitration degenerates to requester 0 with the same timing.

Decomposition:
- Shared package/header uart_pkg:
  - State encoding constants (IDLE/PULSE/WAIT).
  - FRAME_CYCLES computation helper, so it stays consistent with the TX bit timing.
  - IDW helper.
- One sub-module: uart_rr_picker. Combinational: inputs are req mask, ptr, lock_en, lock_id. Outputs are a valid flag, the one-hot grant and the winner index.
- Timer and FSM stay in uart_tx_scheduler.

Test Plan:
Bench configuration: N_REQ=4, INPUT_CLK=1000, BAUD_RATE=100, GUARD_CYCLES=4, giving BIT_CYCLES=11 and FRAME_CYCLES=114.
1. Single byte: req 2 sends 0xA5 with last=1 -> req_ready[2] high 1 cycle; send_en high next cycle with send_byte=0xA5; busy high for 115 cycles; ptr=3; locked stays 0.
2. All four requesters valid, last=1, from reset -> grants in order 0,1,2,3,0; send_en pulses exactly 116 cycles apart; decoded tx_uart bytes match.
3. Packet lock: req 1 sends 3 bytes (last on byte 3) while req 0 and req 3 stay valid -> req 1 bytes go consecutively; locked=1 until byte 3 is accepted; next grant goes to req 3, then req 0.
4. Owner stall: req 1 sends a non-last byte, then drops valid for 500 cycles while req 2 is valid -> no req_ready[2] and no send_en while stalled; resumes when req 1 returns.
5. kill 40 cycles into WAIT -> all outputs 0 the next cycle; locked=0; ptr=0; tx_uart high; the next request is served normally.
6. Handshake check: req_valid pulsed during PULSE/WAIT only -> req_ready never asserted; no transfer occurs.
